master_tx_ps2: RTL and testbench
================================

// Module: master_tx_PS2
// PURPOSE
//  PS/2 device-side transmitter: serialises one byte per request into an 11-bit PS/2 frame.
//  Frame = start(0), 8 data LSB-first, parity, stop(1). Drives SCL and SDA itself.
//  Sits opposite the PS/2 receiver: keyboard/mouse emulation, loopback tests, and
//  feeding any downstream PS/2 sink on the board.
// PARAMETERS
//  HALF_PERIOD  2500  clk cycles per SCL half-period (50 MHz -> 10 kHz SCL); must be >= 4, even
//  PARITY_ODD   1     1: parity bit makes the count of ones over data+parity odd; 0: even
//  GAP_SLOTS    1     idle bit-slots (SCL=SDA=1) enforced after each stop bit
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active low
//  data_in      in   8  byte to send; captured on an accepted load
//  data_load    in   1  request; accepted when data_load && ready
//  inhibit      in   1  host holds bus (SCL pulled low), async; 2-FF synchronised inside
//  ready        out  1  1 = idle, can accept a byte
//  SCL          out  1  PS/2 clock, idle high
//  SDA          out  1  PS/2 data, idle high
//  tx_done      out  1  1-cycle pulse: frame completed, including its stop slot
//  tx_error     out  1  1-cycle pulse: frame aborted by inhibit
// BEHAVIOUR
//  Reset (async, rst=0): SCL=1, SDA=1, ready=1, tx_done=0, tx_error=0, FSM=IDLE, counters=0.
//   Reset mid-frame frees the bus on the same edge. The partial frame is lost.
//  Bit slot: 2*HALF_PERIOD cycles, with a phase counter ph = 0..2*HALF_PERIOD-1.
//   ph 0..HALF-1: SCL=1. ph HALF..2*HALF-1: SCL=0.
//   SDA updates only at ph = HALF/2, so it is stable HALF/2 cycles before the SCL fall.
//   The sink samples SDA on the SCL falling edge.
//  FSM: IDLE -> START -> DATA(8 slots, bit_cnt 0..7) -> PARITY -> STOP -> GAP(GAP_SLOTS) -> IDLE.
//   IDLE: if data_load && ready && !inhibit_s, latch shreg=data_in and compute the parity bit:
//    par = ^data_in ^ PARITY_ODD.
//    Then ready=0 on the next cycle and enter START with ph=0.
//   IDLE with inhibit_s=1: data_load is ignored, ready=0 while inhibited.
//   DATA: SDA=shreg[0] at ph=HALF/2; shift right at slot end. bit_cnt wraps 7->PARITY.
//   STOP: SDA=1. At the last cycle of the stop slot, tx_done=1 for one cycle.
//   GAP: both lines high. ready returns to 1 on the cycle after the GAP ends.
//  Latency: the accepting edge is cycle 0.
//   First SCL fall at cycle 1+HALF; tx_done at cycle 22*HALF; ready=1 at (22+2*GAP_SLOTS)*HALF+1.
//  data_load while ready=0: ignored, with no queueing. data_in is don't-care outside acceptance.
//  Inhibit, sampled synchronised, in START/DATA/PARITY: abort within 1 cycle.
//   SCL=1, SDA=1, tx_error pulse, go to GAP, then IDLE. The byte is dropped.
//  Inhibit in STOP/GAP: ignored. The frame counts as delivered and tx_done still fires.
//  SCL is never driven low while inhibit_s=1 outside an in-progress frame.
//  No output glitches: SCL and SDA are registered outputs.
// STRUCTURE
//  ps2_defs.vh: FSM state encodings, FRAME_BITS=11, START_BIT=1'b0, STOP_BIT=1'b1.
//   Shared with the PS/2 receiver.
//  Sub-module ps2_slot_timer: phase counter, with outputs
//   set_pt (ph==HALF/2), fall_pt (ph==HALF) and slot_end (ph==2*HALF-1).
//   Cleared by the FSM on frame start and on abort.
//  Top: FSM, shift register, bit counter, parity, inhibit synchroniser, output registers.
// TESTING  (HALF_PERIOD=8, GAP_SLOTS=1 in sim)
//  1 Send 0xA5, PARITY_ODD=1. SDA sampled at the 11 SCL falls = 0,1,0,1,0,0,1,0,1,1,1.
//    tx_done at cycle 176; ready=1 at cycle 193.
//  2 Send 0x00 -> parity bit 1. Send 0xFF -> parity 1.
//    Repeat with PARITY_ODD=0 -> parity bits 0 and 0.
//  3 Pulse data_load with 0x3C at cycle 40 of a 0x5A frame.
//    Only 0x5A is sent, then the lines idle, and there is no second tx_done.
//  4 Assert inhibit during data bit 3.
//    tx_error pulse within 3 cycles; SCL=SDA=1; no tx_done; ready returns after the GAP.
//    A later load of 0x12 is sent cleanly.
//  5 Hold inhibit in IDLE, assert data_load.
//    Not accepted, ready=0, SCL stays 1. Release inhibit: ready=1 within 3 cycles.
//  6 Drive rst=0 mid-parity slot: SCL=SDA=1 and ready=1 immediately, no pulses.
//    After release, 0xC3 transmits correctly.
//    Back-to-back loads checked with a bit-accurate PS/2 sink model.

Source files
------------

// File: rtl/master_tx_ps2_pkg.sv
// Shared PS/2 framing definitions: FSM encodings, frame layout constants, parity helper.
// The PS/2 receiver imports the same package so both sides agree on the frame format.
package master_tx_ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } ps2_state_e;

    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = FRAME_BITS - 3;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Parity bit for a data byte; odd=1 makes ones(data+parity) odd.
    function automatic logic ps2_parity(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/master_tx_ps2_slot_timer.sv
// Bit-slot phase counter for the PS/2 transmitter: one slot is 2*HALF_PERIOD clocks.
// Flags the SDA update point, the SCL-low half and the last cycle of the slot.
module master_tx_ps2_slot_timer #(
    parameter int HALF_PERIOD = 2500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic set_pt,
    output logic low_ph,
    output logic slot_end
);

    localparam int            PW      = $clog2(2 * HALF_PERIOD);
    localparam logic [PW-1:0] SET_PH  = PW'(HALF_PERIOD / 2);
    localparam logic [PW-1:0] FALL_PH = PW'(HALF_PERIOD);
    localparam logic [PW-1:0] LAST_PH = PW'(2 * HALF_PERIOD - 1);

    logic [PW-1:0] ph;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                ph <= '0;
        else if (clr || slot_end) ph <= '0;
        else                     ph <= ph + 1'b1;
    end

    assign set_pt   = (ph == SET_PH);
    assign low_ph   = (ph >= FALL_PH);
    assign slot_end = (ph == LAST_PH);

endmodule

// File: rtl/master_tx_ps2.sv
// PS/2 device-side transmitter: sends one byte per accepted load as an 11-bit frame
// (start, 8 data LSB-first, parity, stop), driving SCL and SDA from registers.
module master_tx_ps2
    import master_tx_ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2500,
    parameter bit PARITY_ODD  = 1'b1,
    parameter int GAP_SLOTS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_load,
    input  logic       inhibit,
    output logic       ready,
    output logic       SCL,
    output logic       SDA,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int            GW         = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_SLOTS > 0) ? GAP_SLOTS - 1 : 0);
    localparam logic [2:0]    BIT_LAST   = 3'(DATA_BITS - 1);
    localparam ps2_state_e    POST_FRAME = (GAP_SLOTS > 0) ? ST_GAP : ST_IDLE;

    ps2_state_e    state, state_nxt;
    logic [7:0]    shreg;
    logic          par;
    logic [2:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          inh_meta, inh_s;
    logic          set_pt, low_ph, slot_end;
    logic          accept, abort, in_frame;

    assign in_frame = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    assign abort    = inh_s && (state inside {ST_START, ST_DATA, ST_PARITY});
    assign accept   = (state == ST_IDLE) && data_load && ready && !inh_s;

    // Phase is held at zero while idle so an accepted load always starts a fresh slot.
    master_tx_ps2_slot_timer #(.HALF_PERIOD(HALF_PERIOD)) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state == ST_IDLE) || abort),
        .set_pt   (set_pt),
        .low_ph   (low_ph),
        .slot_end (slot_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inh_meta <= 1'b0;
            inh_s    <= 1'b0;
        end else begin
            inh_meta <= inhibit;
            inh_s    <= inh_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_START;
            ST_START:  if (abort) state_nxt = POST_FRAME;
                       else if (slot_end) state_nxt = ST_DATA;
            ST_DATA:   if (abort) state_nxt = POST_FRAME;
                       else if (slot_end && bit_cnt == BIT_LAST) state_nxt = ST_PARITY;
            ST_PARITY: if (abort) state_nxt = POST_FRAME;
                       else if (slot_end) state_nxt = ST_STOP;
            ST_STOP:   if (slot_end) state_nxt = POST_FRAME;
            ST_GAP:    if (slot_end && gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            par     <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                shreg   <= data_in;
                par     <= ps2_parity(data_in, PARITY_ODD);
                bit_cnt <= '0;
            end else if (state == ST_DATA && slot_end) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state != ST_GAP) gap_cnt <= '0;
            else if (slot_end)   gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Line drivers lag the phase counter by one clock, so every output is a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SCL      <= 1'b1;
            SDA      <= 1'b1;
            ready    <= 1'b1;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            tx_done  <= (state == ST_STOP) && slot_end;
            tx_error <= abort;
            ready    <= (state == ST_IDLE) && (state_nxt == ST_IDLE) && !inh_s;
            if (abort || !in_frame) begin
                SCL <= 1'b1;
                SDA <= 1'b1;
            end else begin
                SCL <= !low_ph;
                if (set_pt) begin
                    case (state)
                        ST_START:  SDA <= START_BIT;
                        ST_DATA:   SDA <= shreg[0];
                        ST_PARITY: SDA <= par;
                        default:   SDA <= STOP_BIT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_master_tx_ps2.sv
// Bench for master_tx_ps2: odd- and even-parity instances share stimulus; a sink model
// captures SDA at each SCL fall and frames are compared against a byte-level reference.
module tb_master_tx_ps2;

    localparam int HALF = 8;
    localparam int GAP  = 1;
    localparam int SLOT = 2 * HALF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_load = 1'b0;
    logic       inhibit = 1'b0;
    logic       ready0, scl0, sda0, done0, err0;
    logic       ready1, scl1, sda1, done1, err1;

    int total = 0;
    int passed = 0;
    int done_cnt0 = 0, err_cnt0 = 0, done_cnt1 = 0;
    logic q0[$];
    logic q1[$];
    logic scl0_d = 1'b1, scl1_d = 1'b1;

    always #5 clk = ~clk;

    master_tx_ps2 #(.HALF_PERIOD(HALF), .PARITY_ODD(1'b1), .GAP_SLOTS(GAP)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_load(data_load), .inhibit(inhibit),
        .ready(ready0), .SCL(scl0), .SDA(sda0), .tx_done(done0), .tx_error(err0)
    );

    master_tx_ps2 #(.HALF_PERIOD(HALF), .PARITY_ODD(1'b0), .GAP_SLOTS(GAP)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_load(data_load), .inhibit(inhibit),
        .ready(ready1), .SCL(scl1), .SDA(sda1), .tx_done(done1), .tx_error(err1)
    );

    // PS/2 sink: sample SDA on each SCL falling edge; count completion/abort pulses.
    always @(negedge clk) begin
        if (scl0_d && !scl0) q0.push_back(sda0);
        if (scl1_d && !scl1) q1.push_back(sda1);
        scl0_d = scl0;
        scl1_d = scl1;
        if (done0) done_cnt0++;
        if (err0)  err_cnt0++;
        if (done1) done_cnt1++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    // Expected frame, index i = i-th bit on the wire.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input bit odd);
        logic [10:0] f;
        int ones;
        ones = $countones(d);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        f[9]  = ((ones + (odd ? 1 : 0)) % 2) == 1;
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic logic [10:0] pop_frame(input bit which);
        logic [10:0] f;
        f = 'x;
        if (!which && q0.size() >= 11) for (int i = 0; i < 11; i++) f[i] = q0.pop_front();
        if (which && q1.size() >= 11)  for (int i = 0; i < 11; i++) f[i] = q1.pop_front();
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (ready0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Waits for ready, then presents one byte; returns just after the accepting edge.
    task automatic send(input logic [7:0] b);
        bit ok;
        wait_ready(600, ok);
        total++;
        if (!ok) $display("FAIL send_ready: ready=%0b before byte %02h, required 1", ready0, b);
        else passed++;
        data_in   = b;
        data_load = 1'b1;
        tick();
        data_load = 1'b0;
        data_in   = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total += 5;
        if (scl0 !== 1'b1) $display("FAIL reset_scl: got %b, required 1", scl0); else passed++;
        if (sda0 !== 1'b1) $display("FAIL reset_sda: got %b, required 1", sda0); else passed++;
        if (ready0 !== 1'b1) $display("FAIL reset_ready: got %b, required 1", ready0); else passed++;
        if (done0 !== 1'b0) $display("FAIL reset_done: got %b, required 0", done0); else passed++;
        if (err0 !== 1'b0) $display("FAIL reset_err: got %b, required 0", err0); else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_frame_a5();
        int first_fall, done_at, done_len, ready_at;
        logic prev_scl;
        logic [10:0] got;
        q0.delete();
        q1.delete();
        first_fall = -1; done_at = -1; done_len = 0; ready_at = -1;
        send(8'hA5);
        prev_scl = scl0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (prev_scl && !scl0 && first_fall < 0) first_fall = k;
            prev_scl = scl0;
            if (done0) begin
                done_len++;
                if (done_at < 0) done_at = k;
            end
            if (ready0 && ready_at < 0) ready_at = k;
        end
        total += 6;
        if (first_fall !== 1 + HALF) $display("FAIL a5_first_fall: cycle %0d, required %0d", first_fall, 1 + HALF); else passed++;
        if (done_at !== 22 * HALF) $display("FAIL a5_done_cycle: cycle %0d, required %0d", done_at, 22 * HALF); else passed++;
        if (done_len !== 1) $display("FAIL a5_done_width: %0d cycles, required 1", done_len); else passed++;
        if (ready_at !== (22 + 2 * GAP) * HALF + 1) $display("FAIL a5_ready_cycle: cycle %0d, required %0d", ready_at, (22 + 2 * GAP) * HALF + 1); else passed++;
        got = pop_frame(0);
        if (got !== model_frame(8'hA5, 1)) $display("FAIL a5_frame_odd: got %b, required %b", got, model_frame(8'hA5, 1)); else passed++;
        got = pop_frame(1);
        if (got !== model_frame(8'hA5, 0)) $display("FAIL a5_frame_even: got %b, required %b", got, model_frame(8'hA5, 0)); else passed++;
    endtask

    task automatic test_parity();
        logic [7:0] bytes [8];
        logic [10:0] got;
        bit ok;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        for (int i = 2; i < 8; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            q0.delete();
            q1.delete();
            send(bytes[i]);
            tick();
            wait_ready(600, ok);
            total += 2;
            got = pop_frame(0);
            if (got !== model_frame(bytes[i], 1)) $display("FAIL parity_odd_%02h: got %b, required %b", bytes[i], got, model_frame(bytes[i], 1)); else passed++;
            got = pop_frame(1);
            if (got !== model_frame(bytes[i], 0)) $display("FAIL parity_even_%02h: got %b, required %b", bytes[i], got, model_frame(bytes[i], 0)); else passed++;
        end
    endtask

    task automatic test_load_while_busy();
        int dn, lows;
        logic [10:0] got;
        bit ok;
        q0.delete();
        q1.delete();
        dn = done_cnt0;
        lows = 0;
        send(8'h5A);
        for (int i = 1; i < 40; i++) tick();
        data_in   = 8'h3C;
        data_load = 1'b1;
        tick();
        data_load = 1'b0;
        wait_ready(600, ok);
        got = pop_frame(0);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!scl0 || !sda0) lows++;
        end
        total += 4;
        if (got !== model_frame(8'h5A, 1)) $display("FAIL busy_frame: got %b, required %b", got, model_frame(8'h5A, 1)); else passed++;
        if (q0.size() !== 0) $display("FAIL busy_extra_bits: %0d extra bits, required 0", q0.size()); else passed++;
        if (done_cnt0 - dn !== 1) $display("FAIL busy_done_count: %0d pulses, required 1", done_cnt0 - dn); else passed++;
        if (lows !== 0) $display("FAIL busy_idle_lines: %0d low cycles, required 0", lows); else passed++;
    endtask

    task automatic test_inhibit_abort();
        int dn, en, err_at, lows;
        logic [10:0] got;
        bit ok;
        q0.delete();
        q1.delete();
        dn = done_cnt0;
        en = err_cnt0;
        err_at = -1;
        lows = 0;
        send(8'($urandom));
        for (int i = 1; i <= 4 * SLOT + 4; i++) tick();
        inhibit = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (err0 && err_at < 0) err_at = k;
            if (err_at > 0 && (!scl0 || !sda0)) lows++;
        end
        inhibit = 1'b0;
        for (int i = 0; i < 2 * SLOT + 4 && !ready0; i++) begin
            tick();
            if (!scl0 || !sda0) lows++;
        end
        total += 6;
        if (err_at < 1 || err_at > 3) $display("FAIL abort_err_latency: %0d cycles, required 1..3", err_at); else passed++;
        if (lows !== 0) $display("FAIL abort_lines_high: %0d low cycles, required 0", lows); else passed++;
        if (ready0 !== 1'b1) $display("FAIL abort_ready_return: got %b, required 1", ready0); else passed++;
        if (done_cnt0 !== dn) $display("FAIL abort_no_done: %0d pulses, required %0d", done_cnt0, dn); else passed++;
        if (err_cnt0 - en !== 1) $display("FAIL abort_err_count: %0d pulses, required 1", err_cnt0 - en); else passed++;
        if (q0.size() !== 4) $display("FAIL abort_partial_bits: %0d bits, required 4", q0.size()); else passed++;
        q0.delete();
        q1.delete();
        send(8'h12);
        tick();
        wait_ready(600, ok);
        total++;
        got = pop_frame(0);
        if (got !== model_frame(8'h12, 1)) $display("FAIL abort_resend: got %b, required %b", got, model_frame(8'h12, 1)); else passed++;
    endtask

    task automatic test_inhibit_idle();
        int dn, bad, r_at;
        q0.delete();
        q1.delete();
        dn = done_cnt0;
        bad = 0;
        r_at = -1;
        inhibit = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (ready0 !== 1'b0) $display("FAIL inh_idle_ready: got %b, required 0", ready0); else passed++;
        data_in   = 8'($urandom);
        data_load = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!scl0 || ready0) bad++;
        end
        data_load = 1'b0;
        tick();
        inhibit = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (ready0 && r_at < 0) r_at = k;
        end
        for (int i = 0; i < 40; i++) tick();
        total += 4;
        if (bad !== 0) $display("FAIL inh_idle_held: %0d bad cycles, required 0", bad); else passed++;
        if (r_at < 1 || r_at > 3) $display("FAIL inh_release_ready: cycle %0d, required 1..3", r_at); else passed++;
        if (q0.size() !== 0) $display("FAIL inh_idle_bits: %0d bits sent, required 0", q0.size()); else passed++;
        if (done_cnt0 !== dn) $display("FAIL inh_idle_done: %0d pulses, required %0d", done_cnt0, dn); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int dn, en;
        logic [10:0] got;
        bit ok;
        send(8'h07);
        for (int i = 1; i <= 9 * SLOT + 11; i++) tick();
        dn = done_cnt0;
        en = err_cnt0;
        rst = 1'b0;
        #1;
        total += 5;
        if (scl0 !== 1'b1) $display("FAIL rst_mid_scl: got %b, required 1", scl0); else passed++;
        if (sda0 !== 1'b1) $display("FAIL rst_mid_sda: got %b, required 1", sda0); else passed++;
        if (ready0 !== 1'b1) $display("FAIL rst_mid_ready: got %b, required 1", ready0); else passed++;
        if (done0 !== 1'b0) $display("FAIL rst_mid_done: got %b, required 0", done0); else passed++;
        if (err0 !== 1'b0) $display("FAIL rst_mid_err: got %b, required 0", err0); else passed++;
        tick();
        tick();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 40; i++) tick();
        total++;
        if (done_cnt0 !== dn || err_cnt0 !== en) $display("FAIL rst_mid_pulses: done %0d err %0d, required %0d %0d", done_cnt0, err_cnt0, dn, en); else passed++;
        send(8'hC3);
        tick();
        wait_ready(600, ok);
        total += 2;
        got = pop_frame(0);
        if (got !== model_frame(8'hC3, 1)) $display("FAIL rst_c3_odd: got %b, required %b", got, model_frame(8'hC3, 1)); else passed++;
        got = pop_frame(1);
        if (got !== model_frame(8'hC3, 0)) $display("FAIL rst_c3_even: got %b, required %b", got, model_frame(8'hC3, 0)); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        logic [10:0] got;
        int dn0, dn1;
        bit ok;
        q0.delete();
        q1.delete();
        dn0 = done_cnt0;
        dn1 = done_cnt1;
        for (int i = 0; i < 8; i++) begin
            bytes[i] = 8'($urandom);
            send(bytes[i]);
        end
        tick();
        wait_ready(600, ok);
        for (int i = 0; i < 8; i++) begin
            total += 2;
            got = pop_frame(0);
            if (got !== model_frame(bytes[i], 1)) $display("FAIL b2b_odd_%0d: got %b, required %b", i, got, model_frame(bytes[i], 1)); else passed++;
            got = pop_frame(1);
            if (got !== model_frame(bytes[i], 0)) $display("FAIL b2b_even_%0d: got %b, required %b", i, got, model_frame(bytes[i], 0)); else passed++;
        end
        total += 2;
        if (done_cnt0 - dn0 !== 8) $display("FAIL b2b_done0: %0d pulses, required 8", done_cnt0 - dn0); else passed++;
        if (done_cnt1 - dn1 !== 8) $display("FAIL b2b_done1: %0d pulses, required 8", done_cnt1 - dn1); else passed++;
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity();
        test_load_while_busy();
        test_inhibit_abort();
        test_inhibit_idle();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
